// File: rtl/ysyx_24100006_scoreboard_if.sv
// ysyx_24100006_scoreboard_if: ID/WB request and stall/status bundle between pipeline control and the GPR scoreboard.
interface ysyx_24100006_scoreboard_if #(
   parameter int NREG  = 16,
   parameter int AW    = 4,
   parameter int OUT_W = 4
);
   logic            id_valid;
   logic            ex_ready;
   logic [AW-1:0]   id_rs1;
   logic            id_rs1_ren;
   logic [AW-1:0]   id_rs2;
   logic            id_rs2_ren;
   logic [AW-1:0]   id_rd;
   logic            id_wen;
   logic            wb_valid;
   logic [AW-1:0]   wb_rd;
   logic            wb_wen;
   logic            stall_id;
   logic            issue_fire;
   logic [NREG-1:0] busy_vec;
   logic [OUT_W-1:0] outstanding;
   logic            pipe_idle;
   logic            err_underflow;
   modport master (
      output id_valid, ex_ready, id_rs1, id_rs1_ren, id_rs2, id_rs2_ren, id_rd, id_wen,
             wb_valid, wb_rd, wb_wen,
      input  stall_id, issue_fire, busy_vec, outstanding, pipe_idle, err_underflow
   );
   modport slave (
      input  id_valid, ex_ready, id_rs1, id_rs1_ren, id_rs2, id_rs2_ren, id_rd, id_wen,
             wb_valid, wb_rd, wb_wen,
      output stall_id, issue_fire, busy_vec, outstanding, pipe_idle, err_underflow
   );
endinterface

// File: rtl/ysyx_24100006_scoreboard.sv
// ysyx_24100006_scoreboard: per-GPR pending-writer counters that stall ID on RAW hazards or saturated destinations.
module ysyx_24100006_scoreboard #(
   parameter int NREG  = 16,
   parameter int AW    = 4,
   parameter int CNT_W = 2,
   parameter int OUT_W = 4
) (
   input logic clk,
   input logic rst_n,
   ysyx_24100006_scoreboard_if.slave sb
);
   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic [OUT_W-1:0] out_q, out_d;
   logic             err_q;
   logic             src1_hit, src2_hit, dst_sat, inc, dec, udf, wb_hit;
   logic [NREG-1:0]  inc_v, dec_v, busy;
   assign src1_hit = sb.id_rs1_ren && sb.id_rs1 != '0 && cnt_q[sb.id_rs1] != '0;
   assign src2_hit = sb.id_rs2_ren && sb.id_rs2 != '0 && cnt_q[sb.id_rs2] != '0;
   assign dst_sat  = sb.id_wen && sb.id_rd != '0 && cnt_q[sb.id_rd] == '1;
   assign sb.stall_id   = sb.id_valid && (src1_hit || src2_hit || dst_sat);
   assign sb.issue_fire = sb.id_valid && sb.ex_ready && !sb.stall_id;
   assign inc    = sb.issue_fire && sb.id_wen && sb.id_rd != '0;
   assign wb_hit = sb.wb_valid && sb.wb_wen && sb.wb_rd != '0;
   // a writeback against an empty counter is ignored and only flagged
   assign udf    = wb_hit && cnt_q[sb.wb_rd] == '0;
   assign dec    = wb_hit && !udf;
   assign inc_v  = inc ? NREG'(1) << sb.id_rd : '0;
   assign dec_v  = dec ? NREG'(1) << sb.wb_rd : '0;
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         cnt_d[i] = inc_v[i] && !dec_v[i] ? cnt_q[i] + CNT_W'(1) :
                    dec_v[i] && !inc_v[i] ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
         busy[i]  = i != 0 && cnt_q[i] != '0;
      end
   end
   assign out_d = inc && !dec ? out_q + OUT_W'(1) :
                  dec && !inc ? out_q - OUT_W'(1) : out_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
         out_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         out_q <= out_d;
         err_q <= err_q || udf;
      end
   end
   assign sb.busy_vec      = busy;
   assign sb.outstanding   = out_q;
   assign sb.pipe_idle     = out_q == '0;
   assign sb.err_underflow = err_q;
endmodule

// File: tb/tb_ysyx_24100006_scoreboard.sv
// tb_ysyx_24100006_scoreboard: scenario tasks with a queue of expected post-edge state, plus a randomized model run.
module tb_ysyx_24100006_scoreboard;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   always #5 clk = ~clk;
   ysyx_24100006_scoreboard_if sb ();
   ysyx_24100006_scoreboard dut (.clk(clk), .rst_n(rst_n), .sb(sb));
   typedef struct {
      logic v, exr, r1en, r2en, wen, wv, wwen, es, ef, ee;
      logic [3:0] rs1, rs2, rd, wrd, eo;
      logic [15:0] eb;
   } step_t;
   typedef struct {
      logic [15:0] b;
      logic [3:0]  o;
      logic        e;
   } exp_t;
   exp_t sbq[$];
   function automatic step_t mk(logic v, logic exr, logic [3:0] rs1, logic r1en, logic [3:0] rs2,
                                logic r2en, logic [3:0] rd, logic wen, logic wv, logic [3:0] wrd,
                                logic wwen, logic es, logic ef, logic [15:0] eb, logic [3:0] eo,
                                logic ee);
      step_t s;
      s.v = v; s.exr = exr; s.rs1 = rs1; s.r1en = r1en; s.rs2 = rs2; s.r2en = r2en;
      s.rd = rd; s.wen = wen; s.wv = wv; s.wrd = wrd; s.wwen = wwen;
      s.es = es; s.ef = ef; s.eb = eb; s.eo = eo; s.ee = ee;
      return s;
   endfunction
   task automatic drive(input step_t s);
      sb.id_valid = s.v; sb.ex_ready = s.exr;
      sb.id_rs1 = s.rs1; sb.id_rs1_ren = s.r1en;
      sb.id_rs2 = s.rs2; sb.id_rs2_ren = s.r2en;
      sb.id_rd = s.rd; sb.id_wen = s.wen;
      sb.wb_valid = s.wv; sb.wb_rd = s.wrd; sb.wb_wen = s.wwen;
   endtask
   task automatic test_reset();
      drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (sb.busy_vec !== 16'h0 || sb.outstanding !== 4'h0 || sb.stall_id !== 1'b0 ||
          sb.pipe_idle !== 1'b1 || sb.err_underflow !== 1'b0 || sb.issue_fire !== 1'b0) begin
         bad++;
         $display("FAIL reset busy=%h out=%0d stall=%b idle=%b err=%b fire=%b want 0000/0/0/1/0/0",
                  sb.busy_vec, sb.outstanding, sb.stall_id, sb.pipe_idle, sb.err_underflow, sb.issue_fire);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic test_raw();
      step_t st[$];
      exp_t  e;
      st.push_back(mk(1,1, 0,0, 0,0, 5,1, 0,0,0, 0,1, 16'h0020,1,0));
      st.push_back(mk(1,1, 5,1, 0,0, 6,1, 0,0,0, 1,0, 16'h0020,1,0));
      st.push_back(mk(1,1, 5,1, 0,0, 6,1, 1,5,1, 1,0, 16'h0000,0,0));
      st.push_back(mk(1,1, 5,1, 0,0, 6,1, 0,0,0, 0,1, 16'h0040,1,0));
      st.push_back(mk(1,1, 4,1, 4,1, 4,1, 1,6,1, 0,1, 16'h0010,1,0));
      st.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,4,1, 0,0, 16'h0000,0,0));
      foreach (st[k]) begin
         @(negedge clk);
         drive(st[k]);
         #1;
         total++;
         if (sb.stall_id !== st[k].es || sb.issue_fire !== st[k].ef) begin
            bad++;
            $display("FAIL raw[%0d] stall/fire got %b/%b want %b/%b", k, sb.stall_id, sb.issue_fire, st[k].es, st[k].ef);
         end
         sbq.push_back('{st[k].eb, st[k].eo, st[k].ee});
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         total++;
         if (sb.busy_vec !== e.b || sb.outstanding !== e.o || sb.err_underflow !== e.e || sb.pipe_idle !== (e.o == 0)) begin
            bad++;
            $display("FAIL raw_state[%0d] busy=%h out=%0d err=%b idle=%b want busy=%h out=%0d err=%b", k,
                     sb.busy_vec, sb.outstanding, sb.err_underflow, sb.pipe_idle, e.b, e.o, e.e);
         end
      end
   endtask
   task automatic test_same_cycle();
      step_t st[$];
      exp_t  e;
      st.push_back(mk(1,1, 0,0, 0,0, 3,1, 0,0,0, 0,1, 16'h0008,1,0));
      st.push_back(mk(1,1, 0,0, 0,0, 3,1, 1,3,1, 0,1, 16'h0008,1,0));
      st.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,3,0, 0,0, 16'h0008,1,0));
      st.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,3,1, 0,0, 16'h0000,0,0));
      foreach (st[k]) begin
         @(negedge clk);
         drive(st[k]);
         #1;
         total++;
         if (sb.stall_id !== st[k].es || sb.issue_fire !== st[k].ef) begin
            bad++;
            $display("FAIL same[%0d] stall/fire got %b/%b want %b/%b", k, sb.stall_id, sb.issue_fire, st[k].es, st[k].ef);
         end
         sbq.push_back('{st[k].eb, st[k].eo, st[k].ee});
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         total++;
         if (sb.busy_vec !== e.b || sb.outstanding !== e.o || sb.err_underflow !== e.e || sb.pipe_idle !== (e.o == 0)) begin
            bad++;
            $display("FAIL same_state[%0d] busy=%h out=%0d err=%b idle=%b want busy=%h out=%0d err=%b", k,
                     sb.busy_vec, sb.outstanding, sb.err_underflow, sb.pipe_idle, e.b, e.o, e.e);
         end
      end
   endtask
   task automatic test_saturation();
      step_t st[$];
      exp_t  e;
      st.push_back(mk(1,1, 0,0, 0,0, 7,1, 0,0,0, 0,1, 16'h0080,1,0));
      st.push_back(mk(1,1, 0,0, 0,0, 7,1, 0,0,0, 0,1, 16'h0080,2,0));
      st.push_back(mk(1,1, 0,0, 0,0, 7,1, 0,0,0, 0,1, 16'h0080,3,0));
      st.push_back(mk(1,1, 0,0, 0,0, 7,1, 0,0,0, 1,0, 16'h0080,3,0));
      st.push_back(mk(1,1, 0,0, 0,0, 7,1, 1,7,1, 1,0, 16'h0080,2,0));
      st.push_back(mk(1,1, 0,0, 0,0, 7,1, 0,0,0, 0,1, 16'h0080,3,0));
      st.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,7,1, 0,0, 16'h0080,2,0));
      st.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,7,1, 0,0, 16'h0080,1,0));
      st.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,7,1, 0,0, 16'h0000,0,0));
      foreach (st[k]) begin
         @(negedge clk);
         drive(st[k]);
         #1;
         total++;
         if (sb.stall_id !== st[k].es || sb.issue_fire !== st[k].ef) begin
            bad++;
            $display("FAIL sat[%0d] stall/fire got %b/%b want %b/%b", k, sb.stall_id, sb.issue_fire, st[k].es, st[k].ef);
         end
         sbq.push_back('{st[k].eb, st[k].eo, st[k].ee});
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         total++;
         if (sb.busy_vec !== e.b || sb.outstanding !== e.o || sb.err_underflow !== e.e || sb.pipe_idle !== (e.o == 0)) begin
            bad++;
            $display("FAIL sat_state[%0d] busy=%h out=%0d err=%b idle=%b want busy=%h out=%0d err=%b", k,
                     sb.busy_vec, sb.outstanding, sb.err_underflow, sb.pipe_idle, e.b, e.o, e.e);
         end
      end
   endtask
   task automatic test_x0();
      step_t st[$];
      exp_t  e;
      st.push_back(mk(1,1, 0,0, 0,0, 0,1, 0,0,0, 0,1, 16'h0000,0,0));
      st.push_back(mk(1,1, 0,0, 0,0, 5,1, 0,0,0, 0,1, 16'h0020,1,0));
      st.push_back(mk(1,1, 0,1, 5,0, 0,1, 0,0,0, 0,1, 16'h0020,1,0));
      st.push_back(mk(0,1, 5,1, 5,1, 5,1, 0,0,0, 0,0, 16'h0020,1,0));
      st.push_back(mk(1,0, 5,1, 0,0, 0,0, 0,0,0, 1,0, 16'h0020,1,0));
      st.push_back(mk(1,1, 0,0, 5,1, 0,0, 1,5,1, 1,0, 16'h0000,0,0));
      st.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,0,1, 0,0, 16'h0000,0,0));
      foreach (st[k]) begin
         @(negedge clk);
         drive(st[k]);
         #1;
         total++;
         if (sb.stall_id !== st[k].es || sb.issue_fire !== st[k].ef) begin
            bad++;
            $display("FAIL x0[%0d] stall/fire got %b/%b want %b/%b", k, sb.stall_id, sb.issue_fire, st[k].es, st[k].ef);
         end
         sbq.push_back('{st[k].eb, st[k].eo, st[k].ee});
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         total++;
         if (sb.busy_vec !== e.b || sb.outstanding !== e.o || sb.err_underflow !== e.e || sb.pipe_idle !== (e.o == 0)) begin
            bad++;
            $display("FAIL x0_state[%0d] busy=%h out=%0d err=%b idle=%b want busy=%h out=%0d err=%b", k,
                     sb.busy_vec, sb.outstanding, sb.err_underflow, sb.pipe_idle, e.b, e.o, e.e);
         end
      end
   endtask
   task automatic test_underflow();
      step_t st[$];
      exp_t  e;
      st.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,9,1, 0,0, 16'h0000,0,1));
      st.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0, 16'h0000,0,1));
      st.push_back(mk(1,1, 0,0, 0,0, 9,1, 0,0,0, 0,1, 16'h0200,1,1));
      st.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,9,1, 0,0, 16'h0000,0,1));
      foreach (st[k]) begin
         @(negedge clk);
         drive(st[k]);
         #1;
         total++;
         if (sb.stall_id !== st[k].es || sb.issue_fire !== st[k].ef) begin
            bad++;
            $display("FAIL udf[%0d] stall/fire got %b/%b want %b/%b", k, sb.stall_id, sb.issue_fire, st[k].es, st[k].ef);
         end
         sbq.push_back('{st[k].eb, st[k].eo, st[k].ee});
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         total++;
         if (sb.busy_vec !== e.b || sb.outstanding !== e.o || sb.err_underflow !== e.e || sb.pipe_idle !== (e.o == 0)) begin
            bad++;
            $display("FAIL udf_state[%0d] busy=%h out=%0d err=%b idle=%b want busy=%h out=%0d err=%b", k,
                     sb.busy_vec, sb.outstanding, sb.err_underflow, sb.pipe_idle, e.b, e.o, e.e);
         end
      end
   endtask
   task automatic test_random();
      logic [1:0]  mc [16];
      int          mo;
      logic        me, hz, fire, inc, dec;
      step_t       s;
      exp_t        e, x;
      int          kk;
      for (int j = 0; j < 16; j++) mc[j] = 2'd0;
      mo = 0;
      me = 1'b1;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         s.v = 1'($urandom_range(0, 1)); s.exr = 1'($urandom_range(0, 3) != 0);
         s.rs1 = 4'($urandom_range(0, 15)); s.r1en = 1'($urandom_range(0, 1));
         s.rs2 = 4'($urandom_range(0, 15)); s.r2en = 1'($urandom_range(0, 1));
         s.rd = 4'($urandom_range(0, 15)); s.wen = 1'($urandom_range(0, 1)) && mo < 12;
         s.wv = 1'($urandom_range(0, 1)); s.wwen = 1'($urandom_range(0, 7) != 0);
         kk = $urandom_range(1, 15);
         if (mc[kk] == 0 && $urandom_range(0, 3) != 0)
            for (int j = 1; j < 16; j++) if (mc[j] != 0) kk = j;
         s.wrd = 4'(kk);
         hz = s.v && ((s.r1en && s.rs1 != 0 && mc[s.rs1] != 0) || (s.r2en && s.rs2 != 0 && mc[s.rs2] != 0) ||
                      (s.wen && s.rd != 0 && mc[s.rd] == 2'd3));
         fire = s.v && s.exr && !hz;
         drive(s);
         #1;
         total++;
         if (sb.stall_id !== hz || sb.issue_fire !== fire) begin
            bad++;
            $display("FAIL rand[%0d] stall/fire got %b/%b want %b/%b", n, sb.stall_id, sb.issue_fire, hz, fire);
         end
         inc = fire && s.wen && s.rd != 0;
         dec = s.wv && s.wwen && s.wrd != 0 && mc[s.wrd] != 0;
         if (s.wv && s.wwen && s.wrd != 0 && mc[s.wrd] == 0) me = 1'b1;
         if (dec) begin mc[s.wrd] = mc[s.wrd] - 2'd1; mo = mo - 1; end
         if (inc) begin mc[s.rd] = mc[s.rd] + 2'd1; mo = mo + 1; end
         x.b = 16'h0;
         for (int j = 1; j < 16; j++) x.b[j] = mc[j] != 0;
         x.o = 4'(mo);
         x.e = me;
         sbq.push_back(x);
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         total++;
         if (sb.busy_vec !== e.b || sb.outstanding !== e.o || sb.err_underflow !== e.e || sb.pipe_idle !== (e.o == 0)) begin
            bad++;
            $display("FAIL rand_state[%0d] busy=%h out=%0d err=%b idle=%b want busy=%h out=%0d err=%b", n,
                     sb.busy_vec, sb.outstanding, sb.err_underflow, sb.pipe_idle, e.b, e.o, e.e);
         end
      end
   endtask
   task automatic test_reset_async();
      @(negedge clk);
      drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         drive(mk(1,1, 0,0, 0,0, 5,1, 0,0,0, 0,1, 16'h0020,0,0));
      end
      @(negedge clk);
      drive(mk(1,1, 5,1, 0,0, 0,0, 0,0,0, 1,0, 16'h0020,2,0));
      #1;
      total++;
      if (sb.stall_id !== 1'b1 || sb.outstanding !== 4'd2 || sb.busy_vec !== 16'h0020) begin
         bad++;
         $display("FAIL arst_pre stall=%b out=%0d busy=%h want 1/2/0020", sb.stall_id, sb.outstanding, sb.busy_vec);
      end
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (sb.busy_vec !== 16'h0 || sb.outstanding !== 4'd0 || sb.stall_id !== 1'b0 ||
          sb.pipe_idle !== 1'b1 || sb.err_underflow !== 1'b0) begin
         bad++;
         $display("FAIL arst busy=%h out=%0d stall=%b idle=%b err=%b want 0000/0/0/1/0",
                  sb.busy_vec, sb.outstanding, sb.stall_id, sb.pipe_idle, sb.err_underflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
      @(posedge clk);
      #1;
      total++;
      if (sb.busy_vec !== 16'h0 || sb.outstanding !== 4'd0) begin
         bad++;
         $display("FAIL arst_post busy=%h out=%0d want 0000/0", sb.busy_vec, sb.outstanding);
      end
   endtask
   initial begin
      test_reset();
      test_raw();
      test_same_cycle();
      test_saturation();
      test_x0();
      test_underflow();
      test_random();
      test_reset_async();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
